inst_encoder: RTL and testbench
===============================

# inst_encoder

Streaming RV32I instruction encoder: accepts micro-ops in the core's internal 5-bit op encoding with register indices and a full 32-bit immediate, and produces the architectural 32-bit instruction word. It is the inverse of the instruction decoder and sits between the trace/replay generator and the instruction memory writer. Both sides use valid/ready handshakes. A registered output FIFO decouples the two sides. Unencodable requests are flagged rather than dropped.

## Interface
- DEPTH, 4, output FIFO entries (power of two, ≥2)
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  request accepted when in_valid && in_ready
- in_op  in  5  internal op code (list below)
- in_rs1, in_rs2, in_rd  in  5 each  register indices
- in_imm  in  32  immediate, same scaling as decoder output (U: value<<12; B/J: byte offset)
- in_use_imm  in  1  ALU ops only: 1 = I-type form, 0 = R-type form
- out_valid  out  1  FIFO head valid
- out_ready  in  1  head consumed when out_valid && out_ready
- out_inst  out  32  encoded word (32'h0 when out_err)
- out_err  out  1  head entry unencodable
- enc_count  out  16  count of accepted error-free requests, wraps

## Operation
- Op codes: ADD 0, AND 1, OR 2, SLL 3, SRL 4, SLT 5, SLTU 6, SRA 7, SUB 8, XOR 9, BEQ 10, BGE 11, BNE 12, BGEU 13, LUI 14, AUIPC 15, JAL 16, JALR 17, LB 18, LH 19, LW 20, LBU 21, LHU 22, SB 23, SH 24, SW 25, BLT 26, BLTU 27. Codes 28–31 are illegal.
- ALU ops, use_imm=0: opcode 0110011, standard funct3. funct7 is 0100000 for SUB/SRA and 0 otherwise.
- ALU ops, use_imm=1: opcode 0010011. SLL/SRL/SRA use imm[4:0] as shamt, with funct7 0100000 for SRA. Other ops use imm[11:0]. SUB with use_imm=1 is an error.
- Loads 0000011 and JALR 1100111: I-type. Stores 0100011: S-type. Branches 1100011: B-type. LUI 0110111 / AUIPC 0010111: U-type. JAL 1101111: J-type.
- Fields are taken from in_rs1/in_rs2/in_rd only where the format has them. Unused inputs are ignored.
- Error conditions:
  - illegal op
  - SUB with imm
  - I/S imm not equal to sign-extension of imm[11:0]
  - shift imm[31:5] ≠ 0
  - B imm not equal to sign-extension of imm[12:0], or imm[0]=1
  - J imm not equal to sign-extension of imm[20:0], or imm[0]=1
  - U imm[11:0] ≠ 0
- On error, the entry is still enqueued with out_inst=0 and out_err=1, and enc_count does not increment.
- Encoding is combinational from the inputs. The result is written into the FIFO at the accepting edge.

## Timing
- Reset (rst=0 at posedge): FIFO empty, out_valid=0, out_inst=0, out_err=0, enc_count=0, in_ready=1 on the following cycle. Reset mid-stream discards all queued entries.
- in_ready = !full. It is registered-state-derived with no combinational path from out_ready or in_valid.
- Latency: a request accepted at edge N appears at the FIFO head with out_valid=1 after edge N (visible cycle N+1) if the FIFO was empty.
- Ordering is strict FIFO. The head is held stable while out_valid && !out_ready.
- Simultaneous push and pop when not full: both occur and occupancy is unchanged. When full, no push is allowed even if a pop occurs that cycle.
- Empty: out_valid=0. out_inst/out_err hold their last value and are don't-care.
- Pointer wrap uses log2(DEPTH)+1-bit pointers. enc_count wraps 0xFFFF→0x0000.

## Test plan
- ADD rd=1 rs1=2 rs2=3, use_imm=0 -> 0x003100B3, err=0. ADD rd=1 rs1=0 imm=0xFFFFFFFF, use_imm=1 -> 0xFFF00093.
- SRA rd=3 rs1=3 imm=4, use_imm=1 -> 0x4041D193. LUI rd=5 imm=0x12345000 -> 0x123452B7. SW rs1=2 rs2=5 imm=8 -> 0x00512423.
- BEQ rs1=1 rs2=2 imm=0xFFFFFFFC -> 0xFE208EE3. JAL rd=1 imm=8 -> 0x008000EF.
- Errors: op=28; SUB with use_imm=1; ADD imm=0x800 with use_imm=1; BEQ imm=3; LUI imm=0x1001 -> each gives out_inst=0, out_err=1, enc_count unchanged.
- Backpressure with out_ready=0 and 5 back-to-back requests -> in_ready drops after the 4th acceptance and the 5th is held. Raising out_ready -> outputs drain in order, with one push and one pop per cycle sustained without a bubble.
- rst=0 asserted with 3 entries queued -> next cycle out_valid=0, enc_count=0, in_ready=1. A new request then appears after 1 cycle.

Source files
------------

// File: rtl/inst_encoder.sv
// inst_encoder: turns internal micro-ops into RV32I instruction words and
// queues them (with an error flag) in a small registered FIFO.
module inst_encoder #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_imm,
    input  logic        in_use_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic [15:0] enc_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    localparam logic [4:0] OP_ADD  = 5'd0,  OP_AND  = 5'd1,  OP_OR   = 5'd2,
                           OP_SLL  = 5'd3,  OP_SRL  = 5'd4,  OP_SLT  = 5'd5,
                           OP_SLTU = 5'd6,  OP_SRA  = 5'd7,  OP_SUB  = 5'd8,
                           OP_XOR  = 5'd9,  OP_BEQ  = 5'd10, OP_BGE  = 5'd11,
                           OP_BNE  = 5'd12, OP_BGEU = 5'd13, OP_LUI  = 5'd14,
                           OP_AUIPC = 5'd15, OP_JAL = 5'd16, OP_JALR = 5'd17,
                           OP_LB   = 5'd18, OP_LH   = 5'd19, OP_LW   = 5'd20,
                           OP_LBU  = 5'd21, OP_LHU  = 5'd22, OP_SB   = 5'd23,
                           OP_SH   = 5'd24, OP_SW   = 5'd25, OP_BLT  = 5'd26,
                           OP_BLTU = 5'd27;

    localparam logic [6:0] OPC_OP     = 7'b0110011, OPC_OPIMM = 7'b0010011,
                           OPC_LOAD   = 7'b0000011, OPC_JALR  = 7'b1100111,
                           OPC_STORE  = 7'b0100011, OPC_BRANCH = 7'b1100011,
                           OPC_LUI    = 7'b0110111, OPC_AUIPC = 7'b0010111,
                           OPC_JAL    = 7'b1101111;

    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
    } fmt_e;

    fmt_e        fmt;
    fmt_e        alu_fmt;
    fmt_e        shift_fmt;
    logic [6:0]  alu_opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [6:0]  opc;
    logic        i_ok, sh_ok, b_ok, j_ok, u_ok;
    logic [31:0] enc_inst;
    logic        enc_err;

    logic [AW:0]       wr_ptr, rd_ptr;
    logic [31:0]       inst_mem [DEPTH];
    logic [DEPTH-1:0]  err_mem;
    logic              full, empty, push, pop;

    // ALU ops pick their format from use_imm; shifts have their own I-form
    assign alu_fmt   = in_use_imm ? FMT_I  : FMT_R;
    assign shift_fmt = in_use_imm ? FMT_SH : FMT_R;
    assign alu_opc   = in_use_imm ? OPC_OPIMM : OPC_OP;

    // Immediate range checks for each format
    assign i_ok  = (in_imm == {{20{in_imm[11]}}, in_imm[11:0]});
    assign sh_ok = (in_imm[31:5] == 27'h0);
    assign b_ok  = (in_imm == {{19{in_imm[12]}}, in_imm[12:0]}) && !in_imm[0];
    assign j_ok  = (in_imm == {{11{in_imm[20]}}, in_imm[20:0]}) && !in_imm[0];
    assign u_ok  = (in_imm[11:0] == 12'h000);

    // Classify the op into a format with its opcode and funct fields
    always_comb begin
        fmt = FMT_BAD;
        f3  = 3'b000;
        f7  = 7'b0000000;
        opc = 7'b0000000;
        case (in_op)
            OP_ADD:   begin fmt = alu_fmt;   f3 = 3'b000; opc = alu_opc; end
            OP_SUB:   begin fmt = in_use_imm ? FMT_BAD : FMT_R; f3 = 3'b000;
                            f7 = F7_ALT; opc = OPC_OP; end
            OP_SLL:   begin fmt = shift_fmt; f3 = 3'b001; opc = alu_opc; end
            OP_SLT:   begin fmt = alu_fmt;   f3 = 3'b010; opc = alu_opc; end
            OP_SLTU:  begin fmt = alu_fmt;   f3 = 3'b011; opc = alu_opc; end
            OP_XOR:   begin fmt = alu_fmt;   f3 = 3'b100; opc = alu_opc; end
            OP_SRL:   begin fmt = shift_fmt; f3 = 3'b101; opc = alu_opc; end
            OP_SRA:   begin fmt = shift_fmt; f3 = 3'b101; f7 = F7_ALT;
                            opc = alu_opc; end
            OP_OR:    begin fmt = alu_fmt;   f3 = 3'b110; opc = alu_opc; end
            OP_AND:   begin fmt = alu_fmt;   f3 = 3'b111; opc = alu_opc; end
            OP_BEQ:   begin fmt = FMT_B; f3 = 3'b000; opc = OPC_BRANCH; end
            OP_BNE:   begin fmt = FMT_B; f3 = 3'b001; opc = OPC_BRANCH; end
            OP_BLT:   begin fmt = FMT_B; f3 = 3'b100; opc = OPC_BRANCH; end
            OP_BGE:   begin fmt = FMT_B; f3 = 3'b101; opc = OPC_BRANCH; end
            OP_BLTU:  begin fmt = FMT_B; f3 = 3'b110; opc = OPC_BRANCH; end
            OP_BGEU:  begin fmt = FMT_B; f3 = 3'b111; opc = OPC_BRANCH; end
            OP_LB:    begin fmt = FMT_I; f3 = 3'b000; opc = OPC_LOAD; end
            OP_LH:    begin fmt = FMT_I; f3 = 3'b001; opc = OPC_LOAD; end
            OP_LW:    begin fmt = FMT_I; f3 = 3'b010; opc = OPC_LOAD; end
            OP_LBU:   begin fmt = FMT_I; f3 = 3'b100; opc = OPC_LOAD; end
            OP_LHU:   begin fmt = FMT_I; f3 = 3'b101; opc = OPC_LOAD; end
            OP_JALR:  begin fmt = FMT_I; f3 = 3'b000; opc = OPC_JALR; end
            OP_SB:    begin fmt = FMT_S; f3 = 3'b000; opc = OPC_STORE; end
            OP_SH:    begin fmt = FMT_S; f3 = 3'b001; opc = OPC_STORE; end
            OP_SW:    begin fmt = FMT_S; f3 = 3'b010; opc = OPC_STORE; end
            OP_LUI:   begin fmt = FMT_U; opc = OPC_LUI; end
            OP_AUIPC: begin fmt = FMT_U; opc = OPC_AUIPC; end
            OP_JAL:   begin fmt = FMT_J; opc = OPC_JAL; end
            default:  fmt = FMT_BAD;
        endcase
    end

    // Assemble the instruction word for the format; errors force a zero word
    always_comb begin
        enc_inst = 32'h0;
        enc_err  = 1'b0;
        case (fmt)
            FMT_R:  enc_inst = {f7, in_rs2, in_rs1, f3, in_rd, opc};
            FMT_I:  begin
                enc_err  = !i_ok;
                enc_inst = {in_imm[11:0], in_rs1, f3, in_rd, opc};
            end
            FMT_SH: begin
                enc_err  = !sh_ok;
                enc_inst = {f7, in_imm[4:0], in_rs1, f3, in_rd, opc};
            end
            FMT_S:  begin
                enc_err  = !i_ok;
                enc_inst = {in_imm[11:5], in_rs2, in_rs1, f3, in_imm[4:0], opc};
            end
            FMT_B:  begin
                enc_err  = !b_ok;
                enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, f3,
                            in_imm[4:1], in_imm[11], opc};
            end
            FMT_U:  begin
                enc_err  = !u_ok;
                enc_inst = {in_imm[31:12], in_rd, opc};
            end
            FMT_J:  begin
                enc_err  = !j_ok;
                enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                            in_rd, opc};
            end
            default: enc_err = 1'b1;
        endcase
        if (enc_err) begin
            enc_inst = 32'h0;
        end
    end

    // FIFO status comes only from registered pointers
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                       (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && !full;
    assign pop       = out_valid && out_ready;
    assign out_inst  = inst_mem[rd_ptr[AW-1:0]];
    assign out_err   = err_mem[rd_ptr[AW-1:0]];

    // FIFO storage, pointers and the count of successfully encoded requests
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            enc_count <= 16'h0;
            err_mem   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem[i] <= 32'h0;
            end
        end else begin
            if (push) begin
                inst_mem[wr_ptr[AW-1:0]] <= enc_inst;
                err_mem[wr_ptr[AW-1:0]]  <= enc_err;
                wr_ptr                   <= wr_ptr + PTR_ONE;
                if (!enc_err) begin
                    enc_count <= enc_count + 16'd1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed vector table, handshake corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_inst_encoder;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_op, in_rs1, in_rs2, in_rd;
    logic [31:0] in_imm;
    logic        in_use_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [15:0] enc_count;

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        use_imm;
        logic [31:0] exp_inst;
        logic        exp_err;
    } vec_t;

    vec_t        tbl [21];
    logic [32:0] model_q [$];
    logic [15:0] model_cnt;
    int          checks;
    int          errors;

    inst_encoder #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .in_imm     (in_imm),
        .in_use_imm (in_use_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_inst   (out_inst),
        .out_err    (out_err),
        .enc_count  (enc_count)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint bits(input longint v, input int lo, input int width);
        return (v >> lo) & ((longint'(1) << width) - 1);
    endfunction

    // Reference encoder: classify the op, range-check the immediate as a
    // signed integer and build the word by adding shifted fields
    function automatic logic [32:0] ref_encode(input logic [4:0] op, input logic [4:0] rs1,
                                               input logic [4:0] rs2, input logic [4:0] rd,
                                               input logic [31:0] imm, input logic use_imm);
        int     alu_f3 [10] = '{0, 7, 6, 1, 5, 2, 3, 5, 0, 4};
        int     o, r1, r2, d, f3, f7, opc;
        longint s, u, w;
        bit     bad;
        string  kind;
        o = int'(op); r1 = int'(rs1); r2 = int'(rs2); d = int'(rd);
        s = longint'($signed(imm));
        u = longint'(imm);
        f3 = 0; f7 = 0; opc = 0; bad = 0; kind = "bad"; w = 0;
        if (o <= 9) begin
            f3 = alu_f3[o];
            f7 = (o == 7 || o == 8) ? 32 : 0;
            if (!use_imm) begin kind = "R"; opc = 51; end
            else if (o == 8) kind = "bad";
            else if (o == 3 || o == 4 || o == 7) begin kind = "SH"; opc = 19; end
            else begin kind = "I"; opc = 19; end
        end else begin
            case (o)
                10: begin kind = "B"; f3 = 0; end
                12: begin kind = "B"; f3 = 1; end
                26: begin kind = "B"; f3 = 4; end
                11: begin kind = "B"; f3 = 5; end
                27: begin kind = "B"; f3 = 6; end
                13: begin kind = "B"; f3 = 7; end
                18, 19, 20: begin kind = "I"; f3 = o - 18; opc = 3; end
                21, 22: begin kind = "I"; f3 = o - 17; opc = 3; end
                17: begin kind = "I"; f3 = 0; opc = 103; end
                23, 24, 25: begin kind = "S"; f3 = o - 23; opc = 35; end
                14: begin kind = "U"; opc = 55; end
                15: begin kind = "U"; opc = 23; end
                16: begin kind = "J"; opc = 111; end
                default: kind = "bad";
            endcase
            if (kind == "B") opc = 99;
        end
        case (kind)
            "R":  w = (longint'(f7) << 25) + (longint'(r2) << 20) + (longint'(r1) << 15) +
                      (longint'(f3) << 12) + (longint'(d) << 7) + opc;
            "I":  begin
                bad = !(s >= -2048 && s <= 2047);
                w = (bits(u, 0, 12) << 20) + (longint'(r1) << 15) + (longint'(f3) << 12) +
                    (longint'(d) << 7) + opc;
            end
            "SH": begin
                bad = !(u < 32);
                w = (longint'(f7) << 25) + (bits(u, 0, 5) << 20) + (longint'(r1) << 15) +
                    (longint'(f3) << 12) + (longint'(d) << 7) + opc;
            end
            "S":  begin
                bad = !(s >= -2048 && s <= 2047);
                w = (bits(u, 5, 7) << 25) + (longint'(r2) << 20) + (longint'(r1) << 15) +
                    (longint'(f3) << 12) + (bits(u, 0, 5) << 7) + opc;
            end
            "B":  begin
                bad = !(s >= -4096 && s <= 4094 && (u % 2) == 0);
                w = (bits(u, 12, 1) << 31) + (bits(u, 5, 6) << 25) + (longint'(r2) << 20) +
                    (longint'(r1) << 15) + (longint'(f3) << 12) + (bits(u, 1, 4) << 8) +
                    (bits(u, 11, 1) << 7) + opc;
            end
            "U":  begin
                bad = (u % 4096) != 0;
                w = u + (longint'(d) << 7) + opc;
            end
            "J":  begin
                bad = !(s >= -1048576 && s <= 1048574 && (u % 2) == 0);
                w = (bits(u, 20, 1) << 31) + (bits(u, 1, 10) << 21) + (bits(u, 11, 1) << 20) +
                    (bits(u, 12, 8) << 12) + (longint'(d) << 7) + opc;
            end
            default: bad = 1;
        endcase
        if (bad) return {1'b1, 32'h0};
        return {1'b0, w[31:0]};
    endfunction

    function automatic logic [31:0] rand_imm();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 6))
            0:       return r;
            1:       return {{20{r[11]}}, r[11:0]};
            2:       return {{19{r[12]}}, r[12:1], 1'b0};
            3:       return {{11{r[20]}}, r[20:1], 1'b0};
            4:       return {r[31:12], 12'h000};
            5:       return {27'h0, r[4:0]};
            default: return {26'h0, r[5:0]};
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [4:0] op, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic [31:0] imm, input logic use_imm);
        in_valid   = valid;
        in_op      = op;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_rd      = rd;
        in_imm     = imm;
        in_use_imm = use_imm;
    endtask

    // One clock: check handshake and head against the model, advance both
    task automatic stepCycle();
        bit          push, pop;
        logic [32:0] exp;
        checkOutput("in_ready", 32'(in_ready), 32'(model_q.size() < DEPTH));
        checkOutput("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
        if (model_q.size() != 0) begin
            checkOutput("out_inst", out_inst, model_q[0][31:0]);
            checkOutput("out_err", 32'(out_err), 32'(model_q[0][32]));
        end
        pop  = rst && out_ready && (model_q.size() != 0);
        push = rst && in_valid && (model_q.size() < DEPTH);
        exp  = ref_encode(in_op, in_rs1, in_rs2, in_rd, in_imm, in_use_imm);
        @(posedge clk);
        #1;
        if (!rst) begin
            model_q.delete();
            model_cnt = 16'h0;
        end else begin
            if (pop) void'(model_q.pop_front());
            if (push) begin
                model_q.push_back(exp);
                if (!exp[32]) model_cnt = model_cnt + 16'd1;
            end
        end
        checkOutput("enc_count", 32'(enc_count), 32'(model_cnt));
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        model_cnt = 16'h0;
        rst       = 1'b0;
        out_ready = 1'b0;
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);

        tbl[0]  = '{5'd0,  5'd2, 5'd3, 5'd1, 32'h0000_0000, 1'b0, 32'h003100B3, 1'b0};
        tbl[1]  = '{5'd0,  5'd0, 5'd0, 5'd1, 32'hFFFF_FFFF, 1'b1, 32'hFFF00093, 1'b0};
        tbl[2]  = '{5'd7,  5'd3, 5'd0, 5'd3, 32'h0000_0004, 1'b1, 32'h4041D193, 1'b0};
        tbl[3]  = '{5'd14, 5'd0, 5'd0, 5'd5, 32'h1234_5000, 1'b0, 32'h123452B7, 1'b0};
        tbl[4]  = '{5'd25, 5'd2, 5'd5, 5'd0, 32'h0000_0008, 1'b0, 32'h00512423, 1'b0};
        tbl[5]  = '{5'd10, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC, 1'b0, 32'hFE208EE3, 1'b0};
        tbl[6]  = '{5'd16, 5'd7, 5'd9, 5'd1, 32'h0000_0008, 1'b0, 32'h008000EF, 1'b0};
        tbl[7]  = '{5'd28, 5'd1, 5'd2, 5'd3, 32'h0000_0000, 1'b0, 32'h00000000, 1'b1};
        tbl[8]  = '{5'd8,  5'd2, 5'd3, 5'd1, 32'h0000_0005, 1'b1, 32'h00000000, 1'b1};
        tbl[9]  = '{5'd0,  5'd0, 5'd0, 5'd1, 32'h0000_0800, 1'b1, 32'h00000000, 1'b1};
        tbl[10] = '{5'd10, 5'd1, 5'd2, 5'd0, 32'h0000_0003, 1'b0, 32'h00000000, 1'b1};
        tbl[11] = '{5'd14, 5'd0, 5'd0, 5'd5, 32'h0000_1001, 1'b0, 32'h00000000, 1'b1};
        tbl[12] = '{5'd8,  5'd2, 5'd3, 5'd1, 32'h0000_0000, 1'b0, 32'h403100B3, 1'b0};
        tbl[13] = '{5'd20, 5'd2, 5'd0, 5'd1, 32'hFFFF_FFFC, 1'b0, 32'hFFC12083, 1'b0};
        tbl[14] = '{5'd17, 5'd1, 5'd0, 5'd0, 32'h0000_0000, 1'b0, 32'h00008067, 1'b0};
        tbl[15] = '{5'd26, 5'd1, 5'd2, 5'd0, 32'h0000_0010, 1'b0, 32'h0020C863, 1'b0};
        tbl[16] = '{5'd15, 5'd0, 5'd0, 5'd1, 32'h0000_0000, 1'b0, 32'h00000097, 1'b0};
        tbl[17] = '{5'd3,  5'd1, 5'd0, 5'd1, 32'h0000_0020, 1'b1, 32'h00000000, 1'b1};
        tbl[18] = '{5'd0,  5'd0, 5'd0, 5'd1, 32'h0000_07FF, 1'b1, 32'h7FF00093, 1'b0};
        tbl[19] = '{5'd0,  5'd0, 5'd0, 5'd1, 32'hFFFF_F7FF, 1'b1, 32'h00000000, 1'b1};
        tbl[20] = '{5'd31, 5'd0, 5'd0, 5'd0, 32'h0000_0000, 1'b0, 32'h00000000, 1'b1};

        // Initial reset and reset-state checks
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_inst", out_inst, 32'd0);
        checkOutput("rst_out_err", 32'(out_err), 32'd0);
        checkOutput("rst_enc_count", 32'(enc_count), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors: push one, check head against the table, pop it
        for (int i = 0; i < 21; i++) begin
            out_ready = 1'b0;
            applyStimulus(1'b1, tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
                          tbl[i].imm, tbl[i].use_imm);
            stepCycle();
            applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
            out_ready = 1'b1;
            checkOutput($sformatf("tbl%0d_inst", i), out_inst, tbl[i].exp_inst);
            checkOutput($sformatf("tbl%0d_err", i), 32'(out_err), 32'(tbl[i].exp_err));
            checkOutput($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'd1);
            stepCycle();
        end

        // Backpressure: five back-to-back requests into a stalled FIFO
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 5'd0, 5'(i), 5'(i + 1), 5'(i + 2), 32'h0, 1'b0);
            stepCycle();
            if (i == 3) checkOutput("bp_full_ready", 32'(in_ready), 32'd0);
        end
        checkOutput("bp_held_count", 32'(enc_count), 32'(model_cnt));
        out_ready = 1'b1;
        stepCycle();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 5'd2, 5'(i + 4), 5'(i + 9), 5'(i + 1), 32'h0, 1'b0);
            stepCycle();
            checkOutput("bp_no_bubble", 32'(out_valid), 32'd1);
        end
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
        repeat (5) stepCycle();

        // Reset with three entries queued
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'd9, 5'(i), 5'(i), 5'(i), 32'h0, 1'b0);
            stepCycle();
        end
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
        rst = 1'b0;
        stepCycle();
        rst = 1'b1;
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_rst_enc_count", 32'(enc_count), 32'd0);
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, 5'd16, 5'd0, 5'd0, 5'd1, 32'h8, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
        checkOutput("post_rst_valid", 32'(out_valid), 32'd1);
        checkOutput("post_rst_inst", out_inst, 32'h008000EF);
        out_ready = 1'b1;
        stepCycle();

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 9) < 7), 5'($urandom()), 5'($urandom()),
                          5'($urandom()), 5'($urandom()), rand_imm(), 1'($urandom()));
            out_ready = 1'($urandom_range(0, 9) < 6);
            stepCycle();
        end
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
        out_ready = 1'b1;
        repeat (DEPTH + 1) stepCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
